// File: rtl/bist_pkg.sv
// Shared definitions for the BIST sequencer: FSM state encoding and the
// width of the session index.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_RUN    = 3'd2,
    ST_FINISH = 3'd3,
    ST_DONE   = 3'd4
  } bist_state_e;

  // session_idx is always 4 bits wide, enough for up to 16 sessions
  localparam int SESS_W       = 4;
  localparam int MAX_SESSIONS = 1 << SESS_W;

endpackage

// File: rtl/bist_run_counter.sv
// Run-length counter and pattern toggle for one BIST session.
// cnt counts RUN cycles from 0; last flags cnt == len-1.
// toggle flips on each enabled edge before the last one, drops to 0 on the
// last edge, and stays 0 whenever the counter is not enabled.
module bist_run_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] len,
  output logic             last,
  output logic             toggle
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             toggle_q, toggle_d;

  assign last   = (cnt_q == (len - CNT_W'(1)));
  assign toggle = toggle_q;

  // Next count / toggle; the count stops at len-1 so it can never wrap
  always_comb begin
    cnt_d    = cnt_q;
    toggle_d = 1'b0;
    if (clear) begin
      cnt_d    = '0;
      toggle_d = 1'b0;
    end else if (en) begin
      cnt_d    = last ? cnt_q : cnt_q + CNT_W'(1);
      toggle_d = last ? 1'b0 : ~toggle_q;
    end
  end

  // Counter state, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      toggle_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      toggle_q <= toggle_d;
    end
  end

endmodule

// File: rtl/bist_seq_ctrl.sv
// BIST sequence controller: runs NUM_SESSIONS back-to-back sessions of
// INIT (1 cycle), RUN (n_cycles cycles) and FINISH (signature compare),
// then parks in DONE with the per-session fail mask and overall pass flag.
// Optional feature macro: BIST_ABORT_EN adds an abort input and an aborted
// status output; without it every accepted start runs to completion.
module bist_seq_ctrl
  import bist_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int NUM_SESSIONS = 4,
  parameter int SIG_W        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
`ifdef BIST_ABORT_EN
  input  logic                        abort,
  output logic                        aborted,
`endif
  input  logic                        start,
  input  logic [CNT_W-1:0]            n_cycles,
  input  logic [SIG_W-1:0]            sig_in,
  input  logic [NUM_SESSIONS*SIG_W-1:0] golden,
  output logic                        init,
  output logic                        running,
  output logic                        toggle,
  output logic                        finish,
  output logic                        bist_end,
  output logic [SESS_W-1:0]           session_idx,
  output logic [NUM_SESSIONS-1:0]     fail_mask,
  output logic                        pass
);

  localparam logic [SESS_W-1:0] LAST_SESS = SESS_W'(NUM_SESSIONS - 1);

  bist_state_e             state_q, state_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic [SESS_W-1:0]       sess_q, sess_d;
  logic [NUM_SESSIONS-1:0] fail_q, fail_d;
  logic                    init_q, running_q, finish_q, end_q, pass_q;
  logic                    pass_d;
`ifdef BIST_ABORT_EN
  logic                    aborted_q, aborted_d;
`endif

  logic                    start_acc;
  logic                    run_clear, run_en, run_last;
  logic [SIG_W-1:0]        sel_golden;
  logic [NUM_SESSIONS-1:0] sess_onehot;

  // A start is only honoured between sequences and with a non-zero length
  assign start_acc = start && (n_cycles != '0) &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign run_clear = start_acc || (state_q == ST_INIT);
  assign run_en    = (state_q == ST_RUN);

  bist_run_counter #(
    .CNT_W (CNT_W)
  ) u_run (
    .clk    (clk),
    .reset  (reset),
    .clear  (run_clear),
    .en     (run_en),
    .len    (len_q),
    .last   (run_last),
    .toggle (toggle)
  );

  // Select the golden slice and one-hot fail bit for the current session
  always_comb begin
    sel_golden  = golden[SIG_W-1:0];
    sess_onehot = '0;
    for (int k = 0; k < NUM_SESSIONS; k++) begin
      if (sess_q == SESS_W'(k)) begin
        sel_golden     = golden[k*SIG_W +: SIG_W];
        sess_onehot[k] = 1'b1;
      end
    end
  end

  // Next-state and datapath updates for the sequencer
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sess_d    = sess_q;
    fail_d    = fail_q;
`ifdef BIST_ABORT_EN
    aborted_d = aborted_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc) begin
          state_d   = ST_INIT;
          len_d     = n_cycles;
          sess_d    = '0;
          fail_d    = '0;
`ifdef BIST_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      ST_INIT:   state_d = ST_RUN;
      ST_RUN:    if (run_last) state_d = ST_FINISH;
      ST_FINISH: begin
        if (sig_in != sel_golden) fail_d = fail_q | sess_onehot;
        if (sess_q < LAST_SESS) begin
          sess_d  = sess_q + SESS_W'(1);
          state_d = ST_INIT;
        end else begin
          state_d = ST_DONE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
`ifdef BIST_ABORT_EN
    // Abort cuts any active session short and reports a failed run
    if (abort && ((state_q == ST_INIT) || (state_q == ST_RUN) ||
                  (state_q == ST_FINISH))) begin
      state_d   = ST_DONE;
      aborted_d = 1'b1;
    end
    pass_d = (state_d == ST_DONE) && (fail_d == '0) && !aborted_d;
`else
    pass_d = (state_d == ST_DONE) && (fail_d == '0);
`endif
  end

  // Sequencer FSM with registered state flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      sess_q    <= '0;
      fail_q    <= '0;
      init_q    <= 1'b0;
      running_q <= 1'b0;
      finish_q  <= 1'b0;
      end_q     <= 1'b0;
      pass_q    <= 1'b0;
`ifdef BIST_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sess_q    <= sess_d;
      fail_q    <= fail_d;
      init_q    <= (state_d == ST_INIT);
      running_q <= (state_d == ST_RUN);
      finish_q  <= (state_d == ST_FINISH);
      end_q     <= (state_d == ST_DONE);
      pass_q    <= pass_d;
`ifdef BIST_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign init        = init_q;
  assign running     = running_q;
  assign finish      = finish_q;
  assign bist_end    = end_q;
  assign pass        = pass_q;
  assign session_idx = sess_q;
  assign fail_mask   = fail_q;
`ifdef BIST_ABORT_EN
  assign aborted     = aborted_q;
`endif

endmodule

// File: doc/bist_seq_ctrl.md
BIST_SEQ_CTRL -- requirements
Module: bist_seq_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, meaning the width of the run-length counter and of n_cycles.
REQ-002 The block SHALL have parameter NUM_SESSIONS, default 4, meaning the number of back-to-back BIST sessions per start (range 1..16).
REQ-003 The block SHALL have parameter SIG_W, default 16, meaning the signature width per session.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: level-sampled request to begin a test sequence.
REQ-007 The block SHALL have port n_cycles, input, CNT_W bits: RUN length per session, sampled on accepted start.
REQ-008 The block SHALL have port sig_in, input, SIG_W bits: external MISR signature, sampled in FINISH.
REQ-009 The block SHALL have port golden, input, NUM_SESSIONS*SIG_W bits: expected signatures; session k occupies bits [k*SIG_W +: SIG_W].
REQ-010 The block SHALL have ports init, running, toggle, finish and bist_end, each output, 1 bit: state flags and pattern toggle.
REQ-011 The block SHALL have port session_idx, output, 4 bits: index of the current session.
REQ-012 The block SHALL have port fail_mask, output, NUM_SESSIONS bits: per-session mismatch flags.
REQ-013 The block SHALL have port pass, output, 1 bit: overall result, valid while bist_end=1.

Function
REQ-014 The FSM SHALL have states IDLE, INIT, RUN, FINISH and DONE; init, running, finish and bist_end SHALL be Moore decodes of INIT, RUN, FINISH and DONE respectively.
REQ-015 In IDLE or DONE, start=1 with n_cycles!=0 SHALL move to INIT next cycle, latch len_q=n_cycles, and clear session_idx, fail_mask and toggle.
REQ-016 start=1 with n_cycles==0 SHALL be ignored; start in INIT, RUN or FINISH SHALL be ignored.
REQ-017 INIT SHALL last exactly 1 cycle, clear cnt to 0 and move to RUN.
REQ-018 RUN SHALL last exactly len_q cycles: cnt increments each RUN cycle and the FSM moves to FINISH on the cycle cnt==len_q-1.
REQ-019 toggle SHALL invert on every RUN clock edge where cnt<len_q-1, be forced to 0 on the edge where cnt==len_q-1, and hold 0 outside RUN.
REQ-020 FINISH SHALL last 1 cycle and set fail_mask[session_idx] when sig_in != golden slice[session_idx].
REQ-021 From FINISH, the FSM SHALL go to INIT with session_idx+1 if session_idx<NUM_SESSIONS-1, and to DONE otherwise.
REQ-022 In DONE, bist_end=1 and pass=(fail_mask==0) SHALL hold until reset or an accepted start.
REQ-023 pass SHALL be 0 whenever bist_end=0.
REQ-024 len_q=1 SHALL give a 1-cycle RUN with toggle remaining 0.
REQ-025 cnt SHALL never wrap: len_q=2^CNT_W-1 SHALL complete normally.

Reset
REQ-026 reset SHALL force, asynchronously, state=IDLE, toggle=0, cnt=0, len_q=0, session_idx=0, fail_mask=0 and all flags 0, including when asserted mid-RUN.
REQ-027 The first accepted start after reset deassertion SHALL behave identically to one issued from IDLE.

Configuration
REQ-028 When BIST_ABORT_EN is defined, the block SHALL add input abort (1 bit) and output aborted (1 bit).
REQ-029 With BIST_ABORT_EN defined, abort=1 in INIT, RUN or FINISH SHALL move to DONE next cycle with aborted=1 and pass=0; aborted SHALL clear on accepted start or reset.
REQ-030 Without BIST_ABORT_EN, neither port SHALL exist and sequencing SHALL run to completion.

Structure
REQ-031 A shared package bist_pkg SHALL hold the state enum typedef and the localparams for the session-index width.
REQ-032 The run counter and toggle generator SHALL be a sub-module, bist_run_counter (inputs clear, en, len; outputs last, toggle).

Verification
REQ-033 With NUM_SESSIONS=1, n_cycles=5 and matching signature, start SHALL give init for 1 cycle, running for 5 cycles, toggle 1,0,1,0,0, finish for 1 cycle, then bist_end=1 and pass=1.
REQ-034 With 4 sessions, n_cycles=3 and a mismatch on session 2, the run SHALL end with fail_mask=4'b0100 and pass=0, having taken 4×5 cycles.
REQ-035 n_cycles=0 with start SHALL leave the block in IDLE and leave every output at 0.
REQ-036 reset asserted on RUN cycle 3 SHALL return all outputs to reset values in the same cycle, and a subsequent start SHALL complete normally.
REQ-037 start asserted in DONE SHALL restart the sequence, clearing bist_end and fail_mask.
REQ-038 With BIST_ABORT_EN defined, abort during RUN of session 1 SHALL give DONE next cycle with aborted=1 and pass=0.
